// File: rtl/eq_pkg.sv
// eq_pkg: shared types, constants and fixed-point helpers for the IIR equalizer bank.
package eq_pkg;

   typedef enum logic [1:0] {COEF_A1, COEF_A2, COEF_B1, COEF_B2} coef_idx_e;
   typedef enum logic [1:0] {IDLE, RUN, SETTLE} state_e;

   localparam int COEF_FRAC_DEF = 14;
   localparam int COEF_ONE      = 1 << COEF_FRAC_DEF;

   // Round half up, then drop the coefficient fraction bits.
   function automatic logic signed [63:0] round_shift(input logic signed [63:0] acc, input int frac);
      return (acc + (64'sd1 <<< (frac - 1))) >>> frac;
   endfunction

   function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      return v > hi ? hi : (v < lo ? lo : v);
   endfunction

endpackage

// File: rtl/eq_coef_bank.sv
// eq_coef_bank: NUM_BANKS x 4 coefficient register file, one write port, one bank read port.
module eq_coef_bank
   import eq_pkg::*;
#(
   parameter int NUM_BANKS = 8,
   parameter int COEF_W    = 18,
   parameter int COEF_FRAC = 14
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          we,
   input  logic [$clog2(NUM_BANKS)-1:0]  wbank,
   input  logic [1:0]                    widx,
   input  logic signed [COEF_W-1:0]      wdata,
   input  logic [$clog2(NUM_BANKS)-1:0]  rbank,
   output logic signed [COEF_W-1:0]      coef [4]
);

   localparam logic signed [COEF_W-1:0] ONE = COEF_W'(64'sd1 <<< COEF_FRAC);

   logic signed [COEF_W-1:0] mem_q [NUM_BANKS][4];

   // Default bank is a pure one-sample delay: b1 = 1.0, everything else zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < NUM_BANKS; b++)
            for (int i = 0; i < 4; i++)
               mem_q[b][i] <= (i == int'(COEF_B1)) ? ONE : '0;
      end else if (we) begin
         mem_q[wbank][widx] <= wdata;
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++)
         coef[i] = mem_q[rbank][i];
   end

endmodule

// File: rtl/iir_eq_bank.sv
// iir_eq_bank: banked second-order fixed-point IIR equalizer with slicer and
// post-coefficient-change settle window.
module iir_eq_bank
   import eq_pkg::*;
#(
   parameter int DATA_W        = 16,
   parameter int COEF_W        = 18,
   parameter int COEF_FRAC     = 14,
   parameter int ACC_W         = 40,
   parameter int NUM_BANKS     = 8,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic signed [DATA_W-1:0]      in_sample,
   input  logic [$clog2(NUM_BANKS)-1:0]  bank_sel,
   input  logic                          cfg_we,
   input  logic [$clog2(NUM_BANKS)-1:0]  cfg_bank,
   input  logic [1:0]                    cfg_idx,
   input  logic signed [COEF_W-1:0]      cfg_wdata,
   input  logic signed [DATA_W-1:0]      thresh,
   output logic                          out_valid,
   output logic signed [DATA_W-1:0]      out_sample,
   output logic                          out_bit,
   output logic                          settling,
   output logic                          sat_flag
);

   localparam int BW = $clog2(NUM_BANKS);
   localparam int CW = $clog2(SETTLE_CYCLES + 1);

   logic signed [COEF_W-1:0] coef [4];
   state_e                   state_q, state_d;
   logic [BW-1:0]            bank_q;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic signed [DATA_W-1:0] u1_q, u2_q, y1_q, y2_q, y_d;
   logic signed [DATA_W-1:0] out_sample_q;
   logic                     out_valid_q, out_bit_q, settling_q, sat_q;
   logic signed [ACC_W-1:0]  acc;
   logic signed [63:0]       rnd, sat;
   logic                     chg, clip, bit_d;

   eq_coef_bank #(
      .NUM_BANKS (NUM_BANKS),
      .COEF_W    (COEF_W),
      .COEF_FRAC (COEF_FRAC)
   ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (cfg_we),
      .wbank (cfg_bank),
      .widx  (cfg_idx),
      .wdata (cfg_wdata),
      .rbank (bank_q),
      .coef  (coef)
   );

   always_comb begin
      acc   = ACC_W'(coef[COEF_A1]) * ACC_W'(y1_q) + ACC_W'(coef[COEF_A2]) * ACC_W'(y2_q)
            + ACC_W'(coef[COEF_B1]) * ACC_W'(u1_q) + ACC_W'(coef[COEF_B2]) * ACC_W'(u2_q);
      rnd   = round_shift(64'(acc), COEF_FRAC);
      sat   = saturate(rnd, DATA_W);
      clip  = sat != rnd;
      y_d   = DATA_W'(sat);
      chg   = (in_valid && bank_sel != bank_q) || (cfg_we && cfg_bank == bank_q);
      // The slicer only trusts samples produced from settled coefficients.
      bit_d = state_q == RUN && y_d >= thresh;
      state_d = state_q;
      cnt_d   = cnt_q;
      if (in_valid) begin
         if (chg) begin
            state_d = SETTLE;
            cnt_d   = CW'(SETTLE_CYCLES);
         end else if (state_q == IDLE) begin
            state_d = RUN;
         end else if (state_q == SETTLE) begin
            cnt_d   = cnt_q - CW'(1);
            state_d = cnt_q == CW'(1) ? RUN : SETTLE;
         end
      end else if (chg && state_q != IDLE) begin
         state_d = SETTLE;
         cnt_d   = CW'(SETTLE_CYCLES);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bank_q       <= '0;
         u1_q         <= '0;
         u2_q         <= '0;
         y1_q         <= '0;
         y2_q         <= '0;
         out_valid_q  <= 1'b0;
         out_sample_q <= '0;
         out_bit_q    <= 1'b0;
         settling_q   <= 1'b0;
         sat_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= in_valid;
         if (in_valid) begin
            bank_q       <= bank_sel;
            u2_q         <= u1_q;
            u1_q         <= in_sample;
            y2_q         <= y1_q;
            y1_q         <= y_d;
            out_sample_q <= y_d;
            out_bit_q    <= bit_d;
            settling_q   <= state_q == SETTLE;
            sat_q        <= sat_q | clip;
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign out_sample = out_sample_q;
   assign out_bit    = out_bit_q;
   assign settling   = settling_q;
   assign sat_flag   = sat_q;

endmodule

// File: tb/tb_iir_eq_bank.sv
// tb_iir_eq_bank: directed self-checking bench for iir_eq_bank.
module tb_iir_eq_bank;
   import eq_pkg::*;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic signed [15:0] in_sample = '0;
   logic [2:0]         bank_sel = '0;
   logic               cfg_we = 1'b0;
   logic [2:0]         cfg_bank = '0;
   logic [1:0]         cfg_idx = '0;
   logic signed [17:0] cfg_wdata = '0;
   logic signed [15:0] thresh = '0;
   logic               out_valid, out_bit, settling, sat_flag;
   logic signed [15:0] out_sample;
   int                 checks = 0;
   int                 errors = 0;

   iir_eq_bank dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_sample  (in_sample),
      .bank_sel   (bank_sel),
      .cfg_we     (cfg_we),
      .cfg_bank   (cfg_bank),
      .cfg_idx    (cfg_idx),
      .cfg_wdata  (cfg_wdata),
      .thresh     (thresh),
      .out_valid  (out_valid),
      .out_sample (out_sample),
      .out_bit    (out_bit),
      .settling   (settling),
      .sat_flag   (sat_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic smp(input int s, input int b);
      in_valid  = 1'b1;
      in_sample = 16'(s);
      bank_sel  = 3'(b);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
   endtask

   task automatic cfg(input int b, input int i, input int d);
      cfg_we    = 1'b1;
      cfg_bank  = 3'(b);
      cfg_idx   = 2'(i);
      cfg_wdata = 18'(d);
      @(posedge clk);
      #1;
      cfg_we    = 1'b0;
   endtask

   initial begin
      int decay [4];
      decay = '{16384, 8192, 4096, 2048};
      #12;
      chk("rst_ov", 32'(out_valid), 0);
      chk("rst_os", 32'(out_sample), 0);
      chk("rst_ob", 32'(out_bit), 0);
      chk("rst_st", 32'(settling), 0);
      chk("rst_sf", 32'(sat_flag), 0);
      @(negedge clk);
      rst = 1'b0;
      // default bank: pure one-sample delay
      smp(1000, 0);
      chk("d1_ov", 32'(out_valid), 1);
      chk("d1_os", 32'(out_sample), 0);
      chk("d1_ob", 32'(out_bit), 0);
      chk("d1_st", 32'(settling), 0);
      smp(2000, 0);
      chk("d2_os", 32'(out_sample), 1000);
      chk("d2_ob", 32'(out_bit), 1);
      smp(-500, 0);
      chk("d3_os", 32'(out_sample), 2000);
      chk("d3_ob", 32'(out_bit), 1);
      @(posedge clk);
      #1;
      chk("idle_ov", 32'(out_valid), 0);
      // bank 1: a1 = 0.5, b1 = 1.0
      cfg(1, 0, 8192);
      cfg(1, 2, COEF_ONE);
      smp(0, 0);
      chk("pre_os", 32'(out_sample), -500);
      chk("pre_st", 32'(settling), 0);
      smp(16384, 1);
      chk("sw_os", 32'(out_sample), 0);
      chk("sw_st", 32'(settling), 0);
      for (int i = 0; i < 16; i++) begin
         smp(0, 1);
         chk("set_st", 32'(settling), 1);
         chk("set_ob", 32'(out_bit), 0);
         if (i < 4) chk("decay_os", 32'(out_sample), decay[i]);
      end
      thresh = 16'sd1;
      smp(0, 1);
      chk("post_st", 32'(settling), 0);
      chk("post_os", 32'(out_sample), 1);
      chk("tie_ob", 32'(out_bit), 1);
      thresh = 16'sd2;
      smp(0, 1);
      chk("below_ob", 32'(out_bit), 0);
      thresh = '0;
      // write to a non-active bank
      cfg(3, 0, 1000);
      smp(0, 1);
      chk("nact_st", 32'(settling), 0);
      chk("nact_os", 32'(out_sample), 1);
      // bank 2: b1 = 4.0, saturation both ways
      cfg(2, 2, 65536);
      smp(30000, 2);
      chk("sat_sw_os", 32'(out_sample), 1);
      chk("sat_sw_sf", 32'(sat_flag), 0);
      smp(-30000, 2);
      chk("satp_os", 32'(out_sample), 32767);
      chk("satp_sf", 32'(sat_flag), 1);
      chk("satp_st", 32'(settling), 1);
      smp(0, 2);
      chk("satn_os", 32'(out_sample), -32768);
      chk("satn_sf", 32'(sat_flag), 1);
      // bank change mid-settle reloads the window
      smp(0, 0);
      chk("reload_st", 32'(settling), 1);
      for (int i = 0; i < 16; i++) begin
         smp(0, 0);
         chk("rl_st", 32'(settling), 1);
      end
      smp(0, 0);
      chk("rl_end_st", 32'(settling), 0);
      chk("rl_end_ob", 32'(out_bit), 1);
      // cfg write to active bank together with a sample
      smp(1000, 0);
      chk("same_pre_os", 32'(out_sample), 0);
      in_valid  = 1'b1;
      in_sample = 16'sd500;
      bank_sel  = 3'd0;
      cfg_we    = 1'b1;
      cfg_bank  = 3'd0;
      cfg_idx   = 2'd2;
      cfg_wdata = 18'sd32768;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      cfg_we    = 1'b0;
      chk("same_old_os", 32'(out_sample), 1000);
      chk("same_old_st", 32'(settling), 0);
      smp(0, 0);
      chk("same_new_os", 32'(out_sample), 1000);
      chk("same_new_st", 32'(settling), 1);
      // reset between in_valid and its out_valid
      in_valid  = 1'b1;
      in_sample = 16'sd7;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mrst_ov", 32'(out_valid), 0);
      chk("mrst_os", 32'(out_sample), 0);
      chk("mrst_sf", 32'(sat_flag), 0);
      chk("mrst_st", 32'(settling), 0);
      chk("mrst_ob", 32'(out_bit), 0);
      @(posedge clk);
      #1;
      chk("mrst_ov2", 32'(out_valid), 0);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      smp(100, 0);
      chk("ar1_ov", 32'(out_valid), 1);
      chk("ar1_os", 32'(out_sample), 0);
      chk("ar1_st", 32'(settling), 0);
      smp(200, 0);
      chk("ar2_os", 32'(out_sample), 100);
      chk("ar2_ob", 32'(out_bit), 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
